// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: registered x/y, hsync, vsync, blank_n and start pulses
// Optional VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

    // hcnt/vcnt address the pixel that the next enabled edge will present
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       hs_act;
    logic       vs_act;
    logic       vis;

    always_comb begin
        h_wrap = (hcnt == H_LAST);
        v_wrap = (vcnt == V_LAST);
        hs_act = ({1'b0, hcnt} >= HS_BEGIN) && ({1'b0, hcnt} < HS_END);
        vs_act = ({1'b0, vcnt} >= VS_BEGIN) && ({1'b0, vcnt} < VS_END);
        vis    = ({1'b0, hcnt} < H_ACT_END) && ({1'b0, vcnt} < V_ACT_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (en) begin
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= v_wrap ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            blank_n     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            x           <= hcnt;
            y           <= vcnt;
            hsync       <= hs_act ? HS_POL : ~HS_POL;
            vsync       <= vs_act ? VS_POL : ~VS_POL;
            blank_n     <= vis;
            line_start  <= (hcnt == 10'd0);
            frame_start <= (hcnt == 10'd0) && (vcnt == 10'd0);
        end else begin
            // pulses last one clk even when en stays low for several clks
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (en && (hcnt == 10'd0) && (vcnt == 10'd0)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
